hazard_stall_ctrl: RTL
======================

// Module: hazard_stall_ctrl
// PURPOSE
//  Pipeline hazard controller between the ID-stage control decoder and the ID/EX register.
//  Detects load-use hazards and taken branches. Drives PC/IF-ID write enables and the IF/ID flush.
//  Owns the registered ID/EX control bundle (EX/M/WB) and injects all-zero (NOP) bubbles.
//  Multi-cycle stalls are sequenced by a small FSM plus a down-counter.
// PARAMETERS
//  LU_STALL  1  load-use stall length in cycles (1..15)
//  CNT_W     16 width of the statistics counters (used only with HAZARD_CTRL_STATS_EN)
// PORTS
//  clk            in   1   system clock, rising edge
//  rst            in   1   synchronous, active-high reset
//  ifid_rs        in   5   rs field of the instruction in IF/ID
//  ifid_rt        in   5   rt field of the instruction in IF/ID
//  idex_memread   in   1   M[1] (MemRead) of the instruction currently in ID/EX
//  idex_rt        in   5   destination rt of the instruction currently in ID/EX
//  branch_taken   in   1   taken branch resolved in MEM, 1-cycle pulse
//  ex_in          in   4   EX control bits from the decoder
//  m_in           in   3   M control bits from the decoder
//  wb_in          in   2   WB control bits from the decoder
//  pc_write       out  1   PC load enable (combinational)
//  ifid_write     out  1   IF/ID load enable (combinational)
//  ifid_flush     out  1   zero the IF/ID instruction (combinational)
//  stall          out  1   high in every stall cycle (combinational)
//  ex_out         out  4   registered ID/EX EX bundle
//  m_out          out  3   registered ID/EX M bundle
//  wb_out         out  2   registered ID/EX WB bundle
// BEHAVIOUR
//  - Single clock domain, clk. Reset is synchronous and active-high on rst.
//  - While rst=1:
//    - pc_write=0, ifid_write=0, ifid_flush=1, stall=0.
//    - At the clock edge: ex_out/m_out/wb_out <= 0, state <= RUN, count <= 0.
//  - Hazard term: hz = idex_memread & (idex_rt!=0) & (idex_rt==ifid_rs | idex_rt==ifid_rt).
//  - FSM states:
//    - RUN: no hazard and no branch -> pc_write=1, ifid_write=1, bundle <= {ex_in,m_in,wb_in}.
//    - RUN, hz=1 -> stall=1, pc_write=0, ifid_write=0, bundle <= 0 (bubble).
//      - If LU_STALL>1: go to STALL with count <= LU_STALL-1. Otherwise stay in RUN.
//    - STALL -> stall=1, pc_write=0, ifid_write=0, bundle <= 0 every cycle, count <= count-1.
//      - Go to RUN on the edge where count==1. hz is ignored while in STALL.
//  - Branch rule (any state, priority over hz and STALL):
//    - pc_write=1 (loads the target), ifid_write=1, ifid_flush=1, stall=0, bundle <= 0.
//    - state <= RUN, count <= 0.
//  - Latency: bundle appears on *_out 1 cycle after it is presented on *_in.
//  - Total stall cycles for one load-use hazard = LU_STALL exactly.
//  - ex_in/m_in/wb_in are passed through bit-exact. Z/X bits are not altered except by a bubble.
// CONFIGURATION
//  HAZARD_CTRL_STATS_EN defined:
//    - Adds output stall_cnt [CNT_W-1:0]: +1 per cycle with stall=1.
//    - Adds output flush_cnt [CNT_W-1:0]: +1 per cycle with branch_taken=1.
//    - Both saturate at all-ones and are cleared by rst.
//  HAZARD_CTRL_STATS_EN not defined:
//    - Neither port exists and no counter logic is built.
//    - All other behaviour is identical.
// TESTING
//  1 rst=1 for 2 cycles -> pc_write=0, ifid_flush=1, *_out=0; release -> pc_write=1, ifid_write=1.
//  2 ex_in=4'b1100, m_in=0, wb_in=2'b10, no hazard -> next cycle ex_out=1100, wb_out=10.
//  3 idex_memread=1, idex_rt=5, ifid_rs=5, LU_STALL=1 -> 1 stall cycle, next *_out=0, then RUN.
//  4 idex_memread=1, idex_rt=0, ifid_rt=0 -> no stall, bundle passes through.
//  5 LU_STALL=3: hazard, then branch_taken in 2nd stall cycle -> ifid_flush=1, stall drops, RUN.
//  6 STATS_EN, CNT_W=4, 20 stall cycles -> stall_cnt=15 (saturated); rst -> stall_cnt=0.

Source files
------------

// File: rtl/hazard_stall_ctrl_if.sv
// hazard_stall_ctrl_if: decoder/ID-EX side signal bundle for the hazard stall controller
// master = pipeline/decoder side (drives hazard inputs and control bits)
// slave  = hazard_stall_ctrl (drives enables, flush, stall and registered ID/EX bundle)
interface hazard_stall_ctrl_if;
  logic [4:0] ifid_rs;
  logic [4:0] ifid_rt;
  logic       idex_memread;
  logic [4:0] idex_rt;
  logic       branch_taken;
  logic [3:0] ex_in;
  logic [2:0] m_in;
  logic [1:0] wb_in;
  logic       pc_write;
  logic       ifid_write;
  logic       ifid_flush;
  logic       stall;
  logic [3:0] ex_out;
  logic [2:0] m_out;
  logic [1:0] wb_out;
  modport master (
    output ifid_rs, ifid_rt, idex_memread, idex_rt, branch_taken, ex_in, m_in, wb_in,
    input  pc_write, ifid_write, ifid_flush, stall, ex_out, m_out, wb_out
  );
  modport slave (
    input  ifid_rs, ifid_rt, idex_memread, idex_rt, branch_taken, ex_in, m_in, wb_in,
    output pc_write, ifid_write, ifid_flush, stall, ex_out, m_out, wb_out
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: load-use/branch hazard control owning the ID/EX EX/M/WB bundle
// Ports: clk, rst (sync, active-high); bus (hazard_stall_ctrl_if.slave) carries
//   hazard inputs, decoder control bits, pc/ifid enables, flush, stall and *_out bundle.
// Optional HAZARD_CTRL_STATS_EN adds CNT_W and saturating stall_cnt/flush_cnt outputs.
module hazard_stall_ctrl #(
  parameter int LU_STALL = 1
`ifdef HAZARD_CTRL_STATS_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic                    clk,
  input  logic                    rst,
  hazard_stall_ctrl_if.slave      bus
`ifdef HAZARD_CTRL_STATS_EN
  , output logic [CNT_W-1:0]      stall_cnt
  , output logic [CNT_W-1:0]      flush_cnt
`endif
);
  typedef enum logic {RUN, STALL} state_t;
  state_t     r_state;
  logic [3:0] r_cnt;
  logic [3:0] r_ex;
  logic [2:0] r_m;
  logic [1:0] r_wb;
  logic       w_hz;
  logic       w_stall;
  logic       w_adv;
  assign w_hz = bus.idex_memread && bus.idex_rt != 5'd0 &&
                (bus.idex_rt == bus.ifid_rs || bus.idex_rt == bus.ifid_rt);
  // a taken branch overrides any stall, including an in-progress multi-cycle one
  assign w_stall = !rst && !bus.branch_taken && (r_state == STALL || w_hz);
  assign w_adv   = !rst && !w_stall;
  assign bus.pc_write   = w_adv;
  assign bus.ifid_write = w_adv;
  assign bus.ifid_flush = rst || bus.branch_taken;
  assign bus.stall      = w_stall;
  assign bus.ex_out     = r_ex;
  assign bus.m_out      = r_m;
  assign bus.wb_out     = r_wb;
  always_ff @(posedge clk) begin
    if (rst || bus.branch_taken) begin
      r_state <= RUN;
      r_cnt   <= '0;
      {r_ex, r_m, r_wb} <= '0;
    end else if (r_state == STALL) begin
      {r_ex, r_m, r_wb} <= '0;
      r_cnt   <= r_cnt - 4'd1;
      r_state <= r_cnt == 4'd1 ? RUN : STALL;
    end else if (w_hz) begin
      {r_ex, r_m, r_wb} <= '0;
      // the hazard cycle itself is the first stall cycle; the counter covers the rest
      if (LU_STALL > 1) begin
        r_state <= STALL;
        r_cnt   <= 4'(LU_STALL - 1);
      end
    end else begin
      {r_ex, r_m, r_wb} <= {bus.ex_in, bus.m_in, bus.wb_in};
    end
  end
`ifdef HAZARD_CTRL_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      stall_cnt <= (w_stall && ~&stall_cnt) ? stall_cnt + 1'b1 : stall_cnt;
      flush_cnt <= (bus.branch_taken && ~&flush_cnt) ? flush_cnt + 1'b1 : flush_cnt;
    end
  end
`endif
endmodule
